io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
//  Device-side end of the core's port I/O req/ack protocol. Answers core IN requests from
//  per-port input holding registers and queues core OUT requests into a shared output FIFO.
//  Bridges both to an external valid/ready stream that feeds inputs and drains outputs.
//  Sits between the processor core and board-level peripherals or the testbench.
// PARAMETERS
//  D_WIDTH    34  data word width; matches the core data path
//  PA_WIDTH   4   port address width; NUM_PORTS = 2**PA_WIDTH input holding registers
//  OUT_DEPTH  4   output FIFO entries; power of 2, >= 2
//  LB_ADDR    15  loopback port address; used only when IO_LOOPBACK_EN is defined
// PORTS
//  clock            in   1         single clock; all logic on posedge
//  reset_i          in   1         synchronous, active-high reset
//  in_req_i         in   1         core IN request; held high until in_ack_o is seen
//  in_addr_i        in   PA_WIDTH  port the core reads; stable while in_req_i is high
//  in_data_o        out  D_WIDTH   read data; valid and stable while in_ack_o is high
//  in_ack_o         out  1         IN acknowledge, 4-phase
//  out_req_i        in   1         core OUT request; held high until out_ack_o is seen
//  out_addr_i       in   PA_WIDTH  destination port; stable while out_req_i is high
//  out_data_i       in   D_WIDTH   write data; stable while out_req_i is high
//  out_ack_o        out  1         OUT acknowledge, 4-phase
//  ext_in_valid_i   in   1         external producer offers a word
//  ext_in_addr_i    in   PA_WIDTH  target input port of the offered word
//  ext_in_data_i    in   D_WIDTH   offered word
//  ext_in_ready_o   out  1         combinational: !in_full[ext_in_addr_i]
//  ext_out_valid_o  out  1         output FIFO non-empty
//  ext_out_addr_o   out  PA_WIDTH  port address of the FIFO head entry
//  ext_out_data_o   out  D_WIDTH   data of the FIFO head entry
//  ext_out_ready_i  in   1         consumer pops the head when valid && ready
//  in_full_o        out  NUM_PORTS per-port holding-register occupancy
// BEHAVIOUR
//  - Reset: in_ack_o=0, out_ack_o=0, in_data_o=0, in_full_o=0, ext_out_valid_o=0, FIFO empty.
//    All register contents and FSM state are cleared. Reset mid-handshake drops ack immediately.
//  - Each direction runs an independent FSM with states IDLE -> ACK -> IDLE. Both acks are registered.
//  - IN FSM:
//    - IDLE: if in_req_i && in_full[in_addr_i], latch data into in_data_o, clear in_full[in_addr_i]
//      and enter ACK; the ack rises on the next cycle (latency 1).
//    - IDLE with the target port empty: stall in IDLE with no ack.
//    - ACK: in_ack_o=1 and in_data_o is held. When in_req_i==0, return to IDLE with ack low next cycle.
//  - OUT FSM:
//    - IDLE: if out_req_i && !fifo_full, push {out_addr_i,out_data_i} and enter ACK. If full, stall.
//    - ACK: out_ack_o=1. When out_req_i==0, return to IDLE.
//  - A request that is still high in ACK is never serviced twice; 4-phase completion is mandatory.
//  - External input: when ext_in_valid_i && ext_in_ready_o, write the word and set in_full[addr].
//    - Push and core consume never target the same port in one cycle: push needs empty, consume needs full.
//    - Pushes and consumes to different ports in the same cycle both take effect.
//  - FIFO:
//    - Occupancy count is 0..OUT_DEPTH. Read and write pointers wrap modulo OUT_DEPTH.
//    - full is computed from the registered count. A pop in the same cycle does not unblock a push.
//    - Push and pop in the same cycle leave the count unchanged.
//    - Ordering is FIFO across all addresses.
// CONFIGURATION
//  IO_LOOPBACK_EN defined:
//   - OUT writes to LB_ADDR bypass the FIFO and go into input holding register LB_ADDR.
//   - Such a write stalls while in_full[LB_ADDR] is set.
//   - ext_in_ready_o is forced to 0 when ext_in_addr_i==LB_ADDR.
//  IO_LOOPBACK_EN undefined:
//   - LB_ADDR is ignored and every OUT write goes to the FIFO.
// STRUCTURE
//  - Package io_pkg holds:
//    - default D_WIDTH and PA_WIDTH
//    - typedef enum {IDLE,ACK} hs_state_t
//    - typedef struct packed {addr,data} io_out_entry_t
//  - Sub-module io_out_fifo: parameterised sync FIFO of io_out_entry_t with count, full and empty.
//  - Top level holds both FSMs, the holding-register array and the loopback mux.
// TESTING
//  1. Push port 3 = 34'h1_2345_6789, then IN req addr 3 -> ack 1 cycle after req with data 0x123456789;
//     in_full_o[3] clears; ack drops 1 cycle after req falls.
//  2. IN req addr 5 with port 5 empty for 10 cycles -> no ack; push port 5 -> ack next cycle.
//  3. Four OUT writes (addr 0..3) with ext_out_ready_i=0 -> four acks, fifth stalls.
//     Then pop one -> fifth acks 2 cycles later; drain order is addr 0,1,2,3,4.
//  4. Same-cycle ext push to port 2 and core IN consume of port 7 -> both complete, in_full_o correct.
//  5. Assert reset_i during IN ACK -> in_ack_o=0 and in_full_o=0 next cycle; stale req is not re-acked
//     until its port is refilled.
//  6. With IO_LOOPBACK_EN: OUT to addr 15 data 7 -> FIFO untouched, in_full_o[15]=1.
//     A following IN from 15 returns 7.

Source files
------------

// File: rtl/io_port_responder_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
// Shared types for the port I/O responder.
//   D_WIDTH / PA_WIDTH : default data word and port address widths
//   hs_state_t         : two-state 4-phase handshake FSM encoding
//   io_out_entry_t     : one output FIFO entry, {port address, data word}
// ---------------------------------------------------------------------------
package io_pkg;

  localparam int D_WIDTH  = 34;
  localparam int PA_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  typedef struct packed {
    logic [PA_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0]  data;
  } io_out_entry_t;

endpackage

// File: rtl/io_port_responder_if.sv
// ---------------------------------------------------------------------------
// io_port_responder_if
// Bundles the core req/ack signals and the external valid/ready streams.
//   slave  : the responder (drives acks, read data, ext_in_ready, ext_out_*)
//   master : the core plus external producer/consumer (drives the rest)
//
// Handshakes:
//   core IN/OUT : 4-phase. req rises, ack rises, req falls, ack falls. The
//                 address/data inputs are stable while req is high and the
//                 read data is stable while in_ack_o is high.
//   ext streams : a word moves on a clock edge where valid && ready. valid
//                 never waits on ready; ready may depend combinationally on
//                 the offered address.
// ---------------------------------------------------------------------------
interface io_port_responder_if #(
  parameter int D_WIDTH   = io_pkg::D_WIDTH,
  parameter int PA_WIDTH  = io_pkg::PA_WIDTH,
  parameter int NUM_PORTS = 2**PA_WIDTH
);

  logic                 in_req_i;
  logic [PA_WIDTH-1:0]  in_addr_i;
  logic [D_WIDTH-1:0]   in_data_o;
  logic                 in_ack_o;

  logic                 out_req_i;
  logic [PA_WIDTH-1:0]  out_addr_i;
  logic [D_WIDTH-1:0]   out_data_i;
  logic                 out_ack_o;

  logic                 ext_in_valid_i;
  logic [PA_WIDTH-1:0]  ext_in_addr_i;
  logic [D_WIDTH-1:0]   ext_in_data_i;
  logic                 ext_in_ready_o;

  logic                 ext_out_valid_o;
  logic [PA_WIDTH-1:0]  ext_out_addr_o;
  logic [D_WIDTH-1:0]   ext_out_data_o;
  logic                 ext_out_ready_i;

  logic [NUM_PORTS-1:0] in_full_o;

  modport slave (
    input  in_req_i, in_addr_i,
    output in_data_o, in_ack_o,
    input  out_req_i, out_addr_i, out_data_i,
    output out_ack_o,
    input  ext_in_valid_i, ext_in_addr_i, ext_in_data_i,
    output ext_in_ready_o,
    output ext_out_valid_o, ext_out_addr_o, ext_out_data_o,
    input  ext_out_ready_i,
    output in_full_o
  );

  modport master (
    output in_req_i, in_addr_i,
    input  in_data_o, in_ack_o,
    output out_req_i, out_addr_i, out_data_i,
    input  out_ack_o,
    output ext_in_valid_i, ext_in_addr_i, ext_in_data_i,
    input  ext_in_ready_o,
    input  ext_out_valid_o, ext_out_addr_o, ext_out_data_o,
    output ext_out_ready_i,
    input  in_full_o
  );

endinterface

// File: rtl/io_port_responder_out_fifo.sv
// ---------------------------------------------------------------------------
// io_out_fifo
// Synchronous FIFO of io_out_entry_t used for core OUT writes.
// Ports:
//   clock, reset_i   : clock, synchronous active-high reset
//   push_i, wdata_i  : write request / entry (ignored while full)
//   pop_i            : pop the head (ignored while empty)
//   rdata_o          : current head entry
//   full_o, empty_o  : derived from the registered count only, so a pop in
//                      the same cycle never lets a push through when full
//   count_o          : occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module io_out_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  io_out_entry_t          wdata_i,
  input  logic                   pop_i,
  output io_out_entry_t          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  io_out_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full_o    = (r_count == (PW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// ---------------------------------------------------------------------------
// io_port_responder
// Device-side end of the core port I/O protocol. Core IN requests are served
// from per-port input holding registers filled by an external valid/ready
// stream; core OUT requests are queued in a shared output FIFO drained by an
// external valid/ready stream.
// Ports:
//   clock, reset_i    : clock, synchronous active-high reset
//   bus (slave)       : core req/ack, external streams, in_full_o
//   dbg_in_state_o    : IN handshake FSM state
//   dbg_out_state_o   : OUT handshake FSM state
//   dbg_fifo_count_o  : output FIFO occupancy
// Build option:
//   IO_LOOPBACK_EN    : OUT writes to LB_ADDR land in input holding register
//                       LB_ADDR instead of the FIFO, and the external
//                       producer may not write that port.
// ---------------------------------------------------------------------------
module io_port_responder
  import io_pkg::*;
#(
  parameter int D_WIDTH   = io_pkg::D_WIDTH,
  parameter int PA_WIDTH  = io_pkg::PA_WIDTH,
  parameter int OUT_DEPTH = 4,
  parameter int LB_ADDR   = 15
) (
  input  logic                       clock,
  input  logic                       reset_i,
  io_port_responder_if.slave         bus,
  output hs_state_t                  dbg_in_state_o,
  output hs_state_t                  dbg_out_state_o,
  output logic [$clog2(OUT_DEPTH):0] dbg_fifo_count_o
);

  localparam int NUM_PORTS = 2**PA_WIDTH;
`ifdef IO_LOOPBACK_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif
  localparam logic [PA_WIDTH-1:0] LB_PORT = PA_WIDTH'(LB_ADDR);

  logic [D_WIDTH-1:0]   r_hold [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_in_full;
  hs_state_t            r_in_state;
  hs_state_t            r_out_state;
  logic                 r_in_ack;
  logic                 r_out_ack;
  logic [D_WIDTH-1:0]   r_in_data;

  logic          w_ext_in_ready;
  logic          w_ext_push;
  logic          w_in_consume;
  logic          w_out_lb;
  logic          w_out_accept;
  logic          w_lb_write;
  logic          w_fifo_push;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  io_out_entry_t w_fifo_wdata;
  io_out_entry_t w_fifo_rdata;

  // The loopback port belongs to the core's OUT path, so the external
  // producer is locked out of it to keep a single writer per port.
  assign w_ext_in_ready = !r_in_full[bus.ext_in_addr_i] &&
                          !(LB_EN && (bus.ext_in_addr_i == LB_PORT));
  assign w_ext_push     = bus.ext_in_valid_i && w_ext_in_ready;

  // Only consume from IDLE: a request still high in ACK must not be served again.
  assign w_in_consume   = (r_in_state == IDLE) && bus.in_req_i && r_in_full[bus.in_addr_i];

  assign w_out_lb       = LB_EN && (bus.out_addr_i == LB_PORT);
  assign w_out_accept   = (r_out_state == IDLE) && bus.out_req_i &&
                          (w_out_lb ? !r_in_full[LB_PORT] : !w_fifo_full);
  assign w_lb_write     = w_out_accept && w_out_lb;
  assign w_fifo_push    = w_out_accept && !w_out_lb;
  assign w_fifo_wdata   = '{addr: bus.out_addr_i, data: bus.out_data_i};

  // Holding registers. A write needs the port empty and a consume needs it
  // full, so the three updates below never collide on one port.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_in_full <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_hold[i] <= '0;
    end else begin
      if (w_ext_push) begin
        r_hold[bus.ext_in_addr_i]    <= bus.ext_in_data_i;
        r_in_full[bus.ext_in_addr_i] <= 1'b1;
      end
      if (w_lb_write) begin
        r_hold[LB_PORT]    <= bus.out_data_i;
        r_in_full[LB_PORT] <= 1'b1;
      end
      if (w_in_consume) r_in_full[bus.in_addr_i] <= 1'b0;
    end
  end

  // IN handshake FSM
  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_in_state <= IDLE;
      r_in_ack   <= 1'b0;
      r_in_data  <= '0;
    end else begin
      case (r_in_state)
        IDLE: if (w_in_consume) begin
          r_in_data  <= r_hold[bus.in_addr_i];
          r_in_ack   <= 1'b1;
          r_in_state <= ACK;
        end
        ACK: if (!bus.in_req_i) begin
          r_in_ack   <= 1'b0;
          r_in_state <= IDLE;
        end
      endcase
    end
  end

  // OUT handshake FSM
  always_ff @(posedge clock) begin
    if (reset_i) begin
      r_out_state <= IDLE;
      r_out_ack   <= 1'b0;
    end else begin
      case (r_out_state)
        IDLE: if (w_out_accept) begin
          r_out_ack   <= 1'b1;
          r_out_state <= ACK;
        end
        ACK: if (!bus.out_req_i) begin
          r_out_ack   <= 1'b0;
          r_out_state <= IDLE;
        end
      endcase
    end
  end

  io_out_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clock   (clock),
    .reset_i (reset_i),
    .push_i  (w_fifo_push),
    .wdata_i (w_fifo_wdata),
    .pop_i   (bus.ext_out_ready_i),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (dbg_fifo_count_o)
  );

  assign bus.in_ack_o        = r_in_ack;
  assign bus.in_data_o       = r_in_data;
  assign bus.out_ack_o       = r_out_ack;
  assign bus.ext_in_ready_o  = w_ext_in_ready;
  assign bus.ext_out_valid_o = !w_fifo_empty;
  assign bus.ext_out_addr_o  = w_fifo_rdata.addr;
  assign bus.ext_out_data_o  = w_fifo_rdata.data;
  assign bus.in_full_o       = r_in_full;
  assign dbg_in_state_o      = r_in_state;
  assign dbg_out_state_o     = r_out_state;

endmodule

// File: tb/tb_io_port_responder.sv
// ---------------------------------------------------------------------------
// tb_io_port_responder
// Directed bench for io_port_responder. IN read data and drained OUT entries
// are predicted into queues when the stimulus is driven and compared when
// the DUT presents them. Build with IO_LOOPBACK_EN to cover the loopback path.
// ---------------------------------------------------------------------------
module tb_io_port_responder;
  import io_pkg::*;

  localparam int DW = 34;
  localparam int AW = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset_i;
  always #5 clock = ~clock;

  io_port_responder_if bus ();
  hs_state_t   dbg_in_state;
  hs_state_t   dbg_out_state;
  logic [2:0]  dbg_fifo_count;

  io_port_responder dut (
    .clock            (clock),
    .reset_i          (reset_i),
    .bus              (bus),
    .dbg_in_state_o   (dbg_in_state),
    .dbg_out_state_o  (dbg_out_state),
    .dbg_fifo_count_o (dbg_fifo_count)
  );

  // scoreboard
  logic [DW-1:0]    in_exp_q[$];
  logic [AW+DW-1:0] out_exp_q[$];
  logic [DW-1:0]    port_model [16];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = {2'($urandom_range(3, 0)), 32'($urandom())};
    return w;
  endfunction

  task automatic ext_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int n = 0;
    bus.ext_in_valid_i = 1'b1;
    bus.ext_in_addr_i  = a;
    bus.ext_in_data_i  = d;
    #1;
    while (!bus.ext_in_ready_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 64'(bus.ext_in_ready_o), 64'd1);
    port_model[a] = d;
    tick();
    bus.ext_in_valid_i = 1'b0;
  endtask

  task automatic core_in(input logic [AW-1:0] a, input string tag);
    int n = 0;
    bus.in_req_i  = 1'b1;
    bus.in_addr_i = a;
    in_exp_q.push_back(port_model[a]);
    do begin tick(); n++; end while (!bus.in_ack_o && n < 20);
    check({tag, "_ack"}, 64'(bus.in_ack_o), 64'd1);
    check({tag, "_data"}, 64'(bus.in_data_o), 64'(in_exp_q.pop_front()));
    bus.in_req_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.in_ack_o && n < 20);
    check({tag, "_ackfall"}, 64'(bus.in_ack_o), 64'd0);
  endtask

  task automatic core_out(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit to_fifo,
                          input string tag);
    int n = 0;
    bus.out_req_i  = 1'b1;
    bus.out_addr_i = a;
    bus.out_data_i = d;
    if (to_fifo) out_exp_q.push_back({a, d});
    do begin tick(); n++; end while (!bus.out_ack_o && n < 20);
    check({tag, "_ack"}, 64'(bus.out_ack_o), 64'd1);
    bus.out_req_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.out_ack_o && n < 20);
    check({tag, "_ackfall"}, 64'(bus.out_ack_o), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.ext_out_ready_i = 1'b1;
    while (out_exp_q.size() > 0 && n < 20) begin
      if (bus.ext_out_valid_o)
        check(tag, 64'({bus.ext_out_addr_o, bus.ext_out_data_o}), 64'(out_exp_q.pop_front()));
      tick();
      n++;
    end
    bus.ext_out_ready_i = 1'b0;
    check({tag, "_sb_empty"}, 64'(out_exp_q.size()), 64'd0);
    check({tag, "_valid_low"}, 64'(bus.ext_out_valid_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] d5;
    bit seen;

    for (int i = 0; i < 16; i++) port_model[i] = '0;
    reset_i             = 1'b1;
    bus.in_req_i        = 1'b0;
    bus.in_addr_i       = '0;
    bus.out_req_i       = 1'b0;
    bus.out_addr_i      = '0;
    bus.out_data_i      = '0;
    bus.ext_in_valid_i  = 1'b0;
    bus.ext_in_addr_i   = '0;
    bus.ext_in_data_i   = '0;
    bus.ext_out_ready_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();

    // reset state
    check("rst_in_ack",    64'(bus.in_ack_o), 64'd0);
    check("rst_out_ack",   64'(bus.out_ack_o), 64'd0);
    check("rst_in_data",   64'(bus.in_data_o), 64'd0);
    check("rst_in_full",   64'(bus.in_full_o), 64'd0);
    check("rst_out_valid", 64'(bus.ext_out_valid_o), 64'd0);

    // 1: push port 3, IN read with latency 1
    ext_push(4'd3, 34'h1_2345_6789, "t1_push");
    check("t1_full3_set", 64'(bus.in_full_o[3]), 64'd1);
    bus.in_req_i  = 1'b1;
    bus.in_addr_i = 4'd3;
    in_exp_q.push_back(port_model[3]);
    tick();
    check("t1_ack_lat1", 64'(bus.in_ack_o), 64'd1);
    check("t1_data", 64'(bus.in_data_o), 64'(in_exp_q.pop_front()));
    check("t1_full3_clr", 64'(bus.in_full_o[3]), 64'd0);
    check("t1_state_ack", 64'(dbg_in_state), 64'(ACK));
    tick();
    check("t1_ack_held", 64'(bus.in_ack_o), 64'd1);
    check("t1_data_held", 64'(bus.in_data_o), 64'h1_2345_6789);
    bus.in_req_i = 1'b0;
    tick();
    check("t1_ack_drop", 64'(bus.in_ack_o), 64'd0);

    // 2: IN from empty port 5 stalls until the port is filled
    bus.in_req_i  = 1'b1;
    bus.in_addr_i = 4'd5;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.in_ack_o) seen = 1'b1;
    end
    check("t2_no_ack_empty", 64'(seen), 64'd0);
    d = rand_word();
    ext_push(4'd5, d, "t2_push");
    in_exp_q.push_back(port_model[5]);
    check("t2_ack_not_yet", 64'(bus.in_ack_o), 64'd0);
    tick();
    check("t2_ack_after_fill", 64'(bus.in_ack_o), 64'd1);
    check("t2_data", 64'(bus.in_data_o), 64'(in_exp_q.pop_front()));
    bus.in_req_i = 1'b0;
    tick();
    check("t2_ack_drop", 64'(bus.in_ack_o), 64'd0);

    // 3: fill the FIFO, fifth write stalls, one pop releases it
    for (int i = 0; i < 4; i++) core_out(AW'(i), rand_word(), 1'b1, $sformatf("t3_w%0d", i));
    check("t3_count_full", 64'(dbg_fifo_count), 64'd4);
    check("t3_valid", 64'(bus.ext_out_valid_o), 64'd1);
    d5 = rand_word();
    bus.out_req_i  = 1'b1;
    bus.out_addr_i = 4'd4;
    bus.out_data_i = d5;
    out_exp_q.push_back({4'd4, d5});
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (bus.out_ack_o) seen = 1'b1;
    end
    check("t3_fifth_stalls", 64'(seen), 64'd0);
    bus.ext_out_ready_i = 1'b1;
    check("t3_head0", 64'({bus.ext_out_addr_o, bus.ext_out_data_o}), 64'(out_exp_q.pop_front()));
    tick();
    bus.ext_out_ready_i = 1'b0;
    check("t3_ack_not_yet", 64'(bus.out_ack_o), 64'd0);
    tick();
    check("t3_ack_2cyc", 64'(bus.out_ack_o), 64'd1);
    check("t3_count_refull", 64'(dbg_fifo_count), 64'd4);
    bus.out_req_i = 1'b0;
    tick();
    check("t3_ack_drop", 64'(bus.out_ack_o), 64'd0);
    drain("t3_drain");

    // 4: ext push to port 2 alongside a core consume of port 7
    ext_push(4'd7, rand_word(), "t4_push7");
    d = rand_word();
    bus.ext_in_valid_i = 1'b1;
    bus.ext_in_addr_i  = 4'd2;
    bus.ext_in_data_i  = d;
    port_model[2]      = d;
    bus.in_req_i       = 1'b1;
    bus.in_addr_i      = 4'd7;
    in_exp_q.push_back(port_model[7]);
    #1;
    check("t4_ready2", 64'(bus.ext_in_ready_o), 64'd1);
    tick();
    bus.ext_in_valid_i = 1'b0;
    check("t4_ack7", 64'(bus.in_ack_o), 64'd1);
    check("t4_data7", 64'(bus.in_data_o), 64'(in_exp_q.pop_front()));
    check("t4_full_vec", 64'(bus.in_full_o), 64'h0004);
    bus.in_req_i = 1'b0;
    tick();

    // 5: reset in the middle of an IN handshake
    ext_push(4'd9, rand_word(), "t5_push9");
    check("t5_full_vec", 64'(bus.in_full_o), 64'h0204);
    bus.in_req_i  = 1'b1;
    bus.in_addr_i = 4'd2;
    in_exp_q.push_back(port_model[2]);
    tick();
    check("t5_ack", 64'(bus.in_ack_o), 64'd1);
    check("t5_data", 64'(bus.in_data_o), 64'(in_exp_q.pop_front()));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("t5_rst_ack", 64'(bus.in_ack_o), 64'd0);
    check("t5_rst_full", 64'(bus.in_full_o), 64'd0);
    check("t5_rst_data", 64'(bus.in_data_o), 64'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (bus.in_ack_o) seen = 1'b1;
    end
    check("t5_no_reack", 64'(seen), 64'd0);
    ext_push(4'd2, rand_word(), "t5_refill");
    in_exp_q.push_back(port_model[2]);
    tick();
    check("t5_reack", 64'(bus.in_ack_o), 64'd1);
    check("t5_redata", 64'(bus.in_data_o), 64'(in_exp_q.pop_front()));
    bus.in_req_i = 1'b0;
    tick();
    check("t5_ack_drop", 64'(bus.in_ack_o), 64'd0);

    // 6: OUT to port 15 (loopback when enabled, FIFO otherwise)
`ifdef IO_LOOPBACK_EN
    core_out(4'd15, 34'd7, 1'b0, "t6_lb_out");
    check("t6_fifo_untouched", 64'(bus.ext_out_valid_o), 64'd0);
    check("t6_full15", 64'(bus.in_full_o[15]), 64'd1);
    bus.ext_in_addr_i = 4'd15;
    #1;
    check("t6_ext_ready15", 64'(bus.ext_in_ready_o), 64'd0);
    port_model[15] = 34'd7;
    core_in(4'd15, "t6_lb_in");
`else
    core_out(4'd15, 34'd7, 1'b1, "t6_out15");
    check("t6_full15", 64'(bus.in_full_o[15]), 64'd0);
    drain("t6_drain");
`endif

    check("end_in_sb_empty", 64'(in_exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
